// File: rtl/button_conditioner_pkg.sv
// Shared defaults, input indices, Up auto-repeat state encoding and the
// output-stage bundle used by the button conditioner.
package button_conditioner_pkg;

  localparam int DEBOUNCE_DEF = 4;
  localparam int HOLD_DEF     = 16;
  localparam int REPEAT_DEF   = 4;

  // Slot of each front-panel input in the debounce-cell array.
  localparam int NUM_INPUTS    = 7;
  localparam int BTN_NEXT      = 0;
  localparam int BTN_UP        = 1;
  localparam int BTN_SET_TIME  = 2;
  localparam int BTN_SET_ALARM = 3;
  localparam int BTN_SNOOZE    = 4;
  localparam int BTN_STOP      = 5;
  localparam int BTN_MUTE      = 6;

  typedef enum logic [1:0] {
    UP_IDLE      = 2'b00,
    UP_WAIT_HOLD = 2'b01,
    UP_REPEATING = 2'b10
  } up_state_e;

  typedef struct packed {
    logic next;
    logic up;
    logic set_time;
    logic set_alarm;
    logic snooze;
    logic stop;
    logic mute;
  } out_s;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// Two-flop synchroniser plus counting debouncer for one raw input; exposes the
// stable level and a one-cycle rise indication (combinational, one cycle wide).
module debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic Clk,
  input  logic Clr,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW     = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output is given a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    prev_d   = stable_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == C_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign rise  = stable_q & ~prev_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the alarm-clock front panel: debounced press pulses, Up auto-repeat,
// SetTime/SetAlarm and Snooze/Stop conflict resolution, and a clean Mute level.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int HOLD     = HOLD_DEF,
  parameter int REPEAT   = REPEAT_DEF
) (
  input  logic Clk,
  input  logic Clr,
  input  logic Next_raw,
  input  logic Up_raw,
  input  logic SetTime_raw,
  input  logic SetAlarm_raw,
  input  logic Snooze_raw,
  input  logic Stop_raw,
  input  logic Mute_raw,
  output logic Next,
  output logic Up,
  output logic SetTime,
  output logic SetAlarm,
  output logic Snooze,
  output logic Stop,
  output logic Mute
);

  localparam int            RW          = $clog2(max_int(HOLD, REPEAT));
  localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD - 1);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT - 1);

  logic [NUM_INPUTS-1:0] raw_vec;
  logic [NUM_INPUTS-1:0] level_vec;
  logic [NUM_INPUTS-1:0] rise_vec;

  assign raw_vec[BTN_NEXT]      = Next_raw;
  assign raw_vec[BTN_UP]        = Up_raw;
  assign raw_vec[BTN_SET_TIME]  = SetTime_raw;
  assign raw_vec[BTN_SET_ALARM] = SetAlarm_raw;
  assign raw_vec[BTN_SNOOZE]    = Snooze_raw;
  assign raw_vec[BTN_STOP]      = Stop_raw;
  assign raw_vec[BTN_MUTE]      = Mute_raw;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_db
    debounce_cell #(
      .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
      .Clk  (Clk),
      .Clr  (Clr),
      .raw  (raw_vec[i]),
      .level(level_vec[i]),
      .rise (rise_vec[i])
    );
  end

  // Only Up and Mute use the level; Mute is never pulse-shaped.
  logic unused_bits;
  assign unused_bits = ^{level_vec[BTN_STOP:BTN_SET_TIME], level_vec[BTN_NEXT],
                         rise_vec[BTN_MUTE]};

  // ---------------------------------------------------------------- Up repeat
  up_state_e     up_state_q, up_state_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_pulse;

  always_comb begin
    up_state_d = up_state_q;
    rep_cnt_d  = rep_cnt_q;
    rep_pulse  = 1'b0;
    if (!level_vec[BTN_UP]) begin
      up_state_d = UP_IDLE;
      rep_cnt_d  = '0;
    end else begin
      unique case (up_state_q)
        UP_IDLE: begin
          if (rise_vec[BTN_UP]) begin
            up_state_d = UP_WAIT_HOLD;
            rep_cnt_d  = '0;
          end
        end
        UP_WAIT_HOLD: begin
          if (rep_cnt_q == HOLD_LAST) begin
            rep_pulse  = 1'b1;
            rep_cnt_d  = '0;
            up_state_d = UP_REPEATING;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        UP_REPEATING: begin
          if (rep_cnt_q == REPEAT_LAST) begin
            rep_pulse = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        default: begin
          up_state_d = UP_IDLE;
          rep_cnt_d  = '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------- output stage
  out_s out_q, out_d;

  always_comb begin
    out_d           = '0;
    out_d.next      = rise_vec[BTN_NEXT];
    out_d.up        = rise_vec[BTN_UP] | rep_pulse;
    // Simultaneous SetTime/SetAlarm is ambiguous, so neither is forwarded;
    // Stop always wins over Snooze.
    out_d.set_time  = rise_vec[BTN_SET_TIME] & ~rise_vec[BTN_SET_ALARM];
    out_d.set_alarm = rise_vec[BTN_SET_ALARM] & ~rise_vec[BTN_SET_TIME];
    out_d.snooze    = rise_vec[BTN_SNOOZE] & ~rise_vec[BTN_STOP];
    out_d.stop      = rise_vec[BTN_STOP];
    out_d.mute      = level_vec[BTN_MUTE];
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      up_state_q <= UP_IDLE;
      rep_cnt_q  <= '0;
      out_q      <= '0;
    end else begin
      up_state_q <= up_state_d;
      rep_cnt_q  <= rep_cnt_d;
      out_q      <= out_d;
    end
  end

  assign Next     = out_q.next;
  assign Up       = out_q.up;
  assign SetTime  = out_q.set_time;
  assign SetAlarm = out_q.set_alarm;
  assign Snooze   = out_q.snooze;
  assign Stop     = out_q.stop;
  assign Mute     = out_q.mute;

endmodule
